// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for a byte-addressed little-endian data memory.
// Sub-word stores become read-modify-write because the memory always writes a full word.
module load_store_unit #(
    parameter int unsigned MEM_BYTES        = 1024,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        MemWrite,
    output logic [31:0] A,
    output logic [31:0] WD,
    input  logic [31:0] RD
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP, S_ERR} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d, ready_q, accept, misal, legal;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d, ext;

    always_comb begin
        accept  = req_valid & req_ready;
        misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                  (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        legal   = (req_we ? req_funct3 inside {3'd0, 3'd1, 3'd2}
                          : req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) &&
                  req_addr <= 32'(MEM_BYTES - 4) && (ALLOW_MISALIGNED || !misal);
        ext     = f3_q == 3'd0 ? {{24{RD[7]}}, RD[7:0]} :
                  f3_q == 3'd1 ? {{16{RD[15]}}, RD[15:0]} :
                  f3_q == 3'd4 ? {24'b0, RD[7:0]} :
                  f3_q == 3'd5 ? {16'b0, RD[15:0]} : RD;
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = '0;
        case (state_q)
            S_IDLE: if (accept) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                state_d = !legal ? S_ERR : (req_we && req_funct3 == 3'd2) ? S_WR : S_RD;
            end
            S_RD: begin
                word_d  = RD;
                rdata_d = we_q ? 32'd0 : ext;
                state_d = we_q ? S_WR : S_RESP;
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            ready_q <= 1'b1;
        end
    end

    // ready_q delays acceptance until the first edge after reset release
    assign req_ready = ready_q && state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP || state_q == S_ERR;
    assign rsp_err   = state_q == S_ERR;
    assign rsp_rdata = rdata_q;
    assign MemWrite  = state_q == S_WR;
    assign A         = state_q == S_IDLE ? 32'd0 : addr_q;
    assign WD        = state_q != S_WR ? 32'd0 :
                       f3_q == 3'd0 ? {word_q[31:8], wdata_q[7:0]} :
                       f3_q == 3'd1 ? {word_q[31:16], wdata_q[15:0]} : wdata_q;
endmodule
